// File: rtl/mips_muldiv_unit.sv
// ---------------------------------------------------------------------------
// mips_muldiv_unit
//
// Multi-cycle MULT/MULTU/DIV/DIVU engine for the execute stage. It also holds
// the architectural HI/LO registers. Operands arrive on the same SrcA/SrcB
// bus as the ALU. The hi/lo outputs feed the SrcA operand mux, which is how
// MFHI/MFLO are implemented.
//
// Ports
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous, active-high
//   start  in   1      launch op (sampled only in IDLE)
//   op     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   mthi   in   1      write SrcA into HI (IDLE only, start has priority)
//   mtlo   in   1      write SrcA into LO (IDLE only, start has priority)
//   SrcA   in   WIDTH  multiplicand / dividend / MTHI-MTLO data
//   SrcB   in   WIDTH  multiplier / divisor
//   busy   out  1      operation in flight; the pipeline stalls while high
//   done   out  1      one-cycle pulse; hi/lo already hold the new result
//   hi     out  WIDTH  HI register
//   lo     out  WIDTH  LO register
//
// Configuration macro: MULDIV_FAST_MUL_EN
//   defined   -> MULT/MULTU use a single-cycle '*' (result one cycle after start)
//   undefined -> MULT/MULTU use the iterative 33-cycle shift-add path
//   DIV/DIVU always use the iterative restoring divider.
// ---------------------------------------------------------------------------
module mips_muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int ITERATIONS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(ITERATIONS + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    // The kind of write-back the FIX cycle has to perform.
    typedef enum logic [1:0] {FIX_MUL, FIX_DIV, FIX_DZ, FIX_FAST} fix_t;

    state_t             state;
    fix_t               fix_kind;
    logic [CNT_W-1:0]   counter;

    // The accumulator is shared by both engines.
    //   MUL: upper half = partial product, lower half = remaining multiplier bits
    //   DIV: upper half = partial remainder, lower half = dividend shifting into quotient
    //   divide-by-zero / fast multiply: holds the raw operands
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;    // multiplicand (MUL) or divisor (DIV), magnitude
    logic               sign_q;     // product / quotient negate (fast mul: signed op)
    logic               sign_r;     // remainder negate

    logic               op_signed;
    logic               op_is_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
`endif

    // Operand conditioning, one step of each iterative engine, and the final
    // sign fix-up. The engines work on magnitudes only. Signs are restored in
    // the FIX cycle.
    always_comb begin
        op_signed = ~op[0];
        op_is_div = op[1];
        a_neg     = op_signed & SrcA[WIDTH-1];
        b_neg     = op_signed & SrcB[WIDTH-1];
        abs_a     = a_neg ? -SrcA : SrcA;
        abs_b     = b_neg ? -SrcB : SrcB;

        // Shift-add step. The carry out of the add becomes the new MSB of
        // the product when the pair shifts right.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Restoring step. Because the remainder stays below the divisor, the
        // MSB of the (WIDTH+1)-bit difference is exactly the borrow.
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

        prod_fix = sign_q ? -acc : acc;
        quo_fix  = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
        fast_prod = sign_q
            ? ({{WIDTH{acc[2*WIDTH-1]}}, acc[2*WIDTH-1:WIDTH]} *
               {{WIDTH{acc[WIDTH-1]}},   acc[WIDTH-1:0]})
            : ({{WIDTH{1'b0}}, acc[2*WIDTH-1:WIDTH]} *
               {{WIDTH{1'b0}}, acc[WIDTH-1:0]});
`endif
    end

    // Controller and datapath registers. busy and done are registered
    // outputs of this FSM. A reset mid-operation simply discards the
    // accumulator, so no partial result ever reaches hi/lo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            fix_kind <= FIX_MUL;
            counter  <= '0;
            acc      <= '0;
            operand  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        counter <= '0;
                        sign_q  <= a_neg ^ b_neg;
                        sign_r  <= a_neg;
                        if (op_is_div) begin
                            if (SrcB == '0) begin
                                // Divide by zero skips iteration. HI gets the
                                // raw dividend in the next (FIX) cycle.
                                acc      <= {SrcA, {WIDTH{1'b0}}};
                                fix_kind <= FIX_DZ;
                                state    <= S_FIX;
                            end else begin
                                acc      <= {{WIDTH{1'b0}}, abs_a};
                                operand  <= abs_b;
                                fix_kind <= FIX_DIV;
                                state    <= S_DIV;
                            end
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            acc      <= {SrcA, SrcB};
                            sign_q   <= op_signed;
                            fix_kind <= FIX_FAST;
                            state    <= S_FIX;
`else
                            acc      <= {{WIDTH{1'b0}}, abs_b};
                            operand  <= abs_a;
                            fix_kind <= FIX_MUL;
                            state    <= S_MUL;
`endif
                        end
                    end else begin
                        if (mthi) hi <= SrcA;
                        if (mtlo) lo <= SrcA;
                    end
                end
                S_MUL: begin
                    acc     <= mul_next;
                    counter <= counter + CNT_W'(1);
                    if (counter == CNT_W'(ITERATIONS - 1)) state <= S_FIX;
                end
                S_DIV: begin
                    acc     <= div_next;
                    counter <= counter + CNT_W'(1);
                    if (counter == CNT_W'(ITERATIONS - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    case (fix_kind)
                        FIX_MUL: begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                        FIX_DIV: begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                        FIX_DZ: begin
                            hi <= acc[2*WIDTH-1:WIDTH];
                            lo <= '1;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        FIX_FAST: begin
                            hi <= fast_prod[2*WIDTH-1:WIDTH];
                            lo <= fast_prod[WIDTH-1:0];
                        end
`endif
                        default: ;
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_muldiv_unit
//
// Self-checking bench for mips_muldiv_unit. Expected HI/LO values come from
// plain 64-bit arithmetic. Expected latency comes from the operation class.
// The bench honours MULDIV_FAST_MUL_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_mips_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        mthi;
    logic        mtlo;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_fail;

    // Observations from the most recent run_op call.
    int          obs_lat;
    int          obs_busy_cycles;
    bit          obs_overlap;
    bit          obs_unstable;
    logic        obs_done_after;
    logic [31:0] obs_hi;
    logic [31:0] obs_lo;

    mips_muldiv_unit #(.WIDTH(32), .ITERATIONS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .SrcA  (src_a),
        .SrcB  (src_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural HI/LO results using 64-bit arithmetic.
    task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] eh, output logic [31:0] el);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = ua * ub; eh = p[63:32]; el = p[31:0]; end
            2'b10: begin
                if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
                else begin
                    sq = sa / sb; sr = sa % sb;
                    p = sq; el = p[31:0];
                    p = sr; eh = p[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
                else begin
                    uq = ua / ub; ur = ua % ub;
                    p = uq; el = p[31:0];
                    p = ur; eh = p[31:0];
                end
            end
        endcase
    endtask

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
        if (o[1] && b == 32'd0) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!o[1]) return 1;
`endif
        return 33;
    endfunction

    // Issue one operation and record what the DUT does. k counts clock edges
    // after the launch edge, and each sample is taken 1 ns after its edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] pre_hi, pre_lo;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        pre_hi = hi; pre_lo = lo;
        @(posedge clk);
        #1;
        start = 1'b0;
        obs_lat = -1; obs_busy_cycles = 0; obs_overlap = 1'b0; obs_unstable = 1'b0;
        for (int k = 0; k <= 100; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (busy && done) obs_overlap = 1'b1;
            if (busy) obs_busy_cycles++;
            if (!done && (hi !== pre_hi || lo !== pre_lo)) obs_unstable = 1'b1;
            if (done) begin obs_lat = k; break; end
        end
        obs_hi = hi; obs_lo = lo;
        @(posedge clk); #1;
        obs_done_after = done;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = 2'b00; mthi = 1'b0; mtlo = 1'b0;
        src_a = 32'd0; src_b = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("[TB] FAIL idle_after_reset: got busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    // Directed cases covering signs, unsigned wrap, overflow and divide by zero.
    task automatic test_directed;
        logic [1:0]  ops [6];
        logic [31:0] as  [6];
        logic [31:0] bs  [6];
        logic [31:0] eh, el;
        ops[0] = 2'b00; as[0] = 32'hFFFF_FFFD; bs[0] = 32'd5;
        ops[1] = 2'b01; as[1] = 32'hFFFF_FFFF; bs[1] = 32'hFFFF_FFFF;
        ops[2] = 2'b10; as[2] = 32'hFFFF_FFF9; bs[2] = 32'd2;
        ops[3] = 2'b11; as[3] = 32'd7;         bs[3] = 32'd2;
        ops[4] = 2'b10; as[4] = 32'h8000_0000; bs[4] = 32'hFFFF_FFFF;
        ops[5] = 2'b11; as[5] = 32'd7;         bs[5] = 32'd0;
        for (int i = 0; i < 6; i++) begin
            ref_model(ops[i], as[i], bs[i], eh, el);
            run_op(ops[i], as[i], bs[i]);
            n_checks++; if (obs_hi !== eh) begin n_fail++; $display("[TB] FAIL directed%0d_hi: got %h expected %h", i, obs_hi, eh); end
            n_checks++; if (obs_lo !== el) begin n_fail++; $display("[TB] FAIL directed%0d_lo: got %h expected %h", i, obs_lo, el); end
            n_checks++; if (obs_lat != exp_lat(ops[i], bs[i])) begin
                n_fail++; $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, obs_lat, exp_lat(ops[i], bs[i]));
            end
            n_checks++; if (obs_busy_cycles != exp_lat(ops[i], bs[i])) begin
                n_fail++; $display("[TB] FAIL directed%0d_busy_cycles: got %0d expected %0d", i, obs_busy_cycles, exp_lat(ops[i], bs[i]));
            end
            n_checks++; if (obs_overlap || obs_unstable || obs_done_after !== 1'b0) begin
                n_fail++; $display("[TB] FAIL directed%0d_protocol: got overlap=%b unstable=%b done_after=%b expected 0/0/0",
                                   i, obs_overlap, obs_unstable, obs_done_after);
            end
        end
    endtask

    function automatic logic [31:0] pick_value();
        logic [31:0] specials [5];
        specials[0] = 32'd0; specials[1] = 32'd1; specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000; specials[4] = 32'h7FFF_FFFF;
        case ($urandom_range(0, 3))
            0:       return 32'($signed($urandom_range(0, 40)) - 20);
            1:       return specials[$urandom_range(0, 4)];
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random;
        logic [1:0]  o;
        logic [31:0] a, b, eh, el;
        int          bad_protocol;
        bad_protocol = 0;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick_value();
            b = pick_value();
            ref_model(o, a, b, eh, el);
            run_op(o, a, b);
            n_checks++; if (obs_hi !== eh) begin n_fail++; $display("[TB] FAIL random%0d_hi op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, obs_hi, eh); end
            n_checks++; if (obs_lo !== el) begin n_fail++; $display("[TB] FAIL random%0d_lo op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, obs_lo, el); end
            n_checks++; if (obs_lat != exp_lat(o, b)) begin
                n_fail++; $display("[TB] FAIL random%0d_latency: got %0d expected %0d", i, obs_lat, exp_lat(o, b));
            end
            if (obs_overlap || obs_unstable || obs_done_after !== 1'b0) bad_protocol++;
        end
        n_checks++; if (bad_protocol != 0) begin
            n_fail++; $display("[TB] FAIL random_protocol: got %0d bad ops expected 0", bad_protocol);
        end
    endtask

    // start/mthi while busy must be dropped. mt* in IDLE writes, and start
    // wins over mthi when both arrive in the same cycle.
    task automatic test_ignored_inputs;
        logic [31:0] eh, el, pre_hi;
        int          lat;
        ref_model(2'b10, 32'hFFFF_FF9C, 32'd7, eh, el);
        @(negedge clk);
        start = 1'b1; op = 2'b10; src_a = 32'hFFFF_FF9C; src_b = 32'd7;
        pre_hi = hi;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            if (k == 10) begin
                start = 1'b1; mthi = 1'b1; op = 2'b01; src_a = 32'hDEAD_BEEF; src_b = 32'd3;
            end
            @(posedge clk); #1;
            start = 1'b0; mthi = 1'b0;
            if (k == 10) begin
                n_checks++; if (hi !== pre_hi || busy !== 1'b1) begin
                    n_fail++; $display("[TB] FAIL mthi_while_busy: got hi=%h busy=%b expected %h/1", hi, busy, pre_hi);
                end
            end
            if (done) begin lat = k; break; end
        end
        n_checks++; if (lat != 33) begin n_fail++; $display("[TB] FAIL ignored_latency: got %0d expected 33", lat); end
        n_checks++; if (hi !== eh || lo !== el) begin
            n_fail++; $display("[TB] FAIL ignored_result: got %h/%h expected %h/%h", hi, lo, eh, el);
        end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL no_queued_start: got busy=%b expected 0", busy); end

        @(negedge clk); mtlo = 1'b1; src_a = 32'h0000_1234;
        @(posedge clk); #1; mtlo = 1'b0;
        n_checks++; if (lo !== 32'h1234 || hi !== eh) begin
            n_fail++; $display("[TB] FAIL mtlo: got %h/%h expected %h/00001234", hi, lo, eh);
        end

        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; src_a = 32'hCAFE_0001;
        @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
        n_checks++; if (hi !== 32'hCAFE_0001 || lo !== 32'hCAFE_0001) begin
            n_fail++; $display("[TB] FAIL mthi_mtlo: got %h/%h expected cafe0001/cafe0001", hi, lo);
        end

        @(negedge clk); start = 1'b1; mthi = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1; start = 1'b0; mthi = 1'b0;
        n_checks++; if (hi !== 32'hCAFE_0001 || busy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL start_priority: got hi=%h busy=%b expected cafe0001/1", hi, busy);
        end
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        n_checks++; if (lat != 33 || hi !== 32'd2 || lo !== 32'd14) begin
            n_fail++; $display("[TB] FAIL priority_result: got lat=%0d %h/%h expected 33 00000002/0000000e", lat, hi, lo);
        end
    endtask

    task automatic test_reset_abort;
        int done_seen;
        @(negedge clk);
        start = 1'b1; op = 2'b00; src_a = 32'hFFFF_FFFD; src_b = 32'd5;
        @(posedge clk); #1; start = 1'b0;
        repeat (14) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++; $display("[TB] FAIL abort_reset: got busy=%b done=%b hi=%h lo=%h expected 0/0/0/0", busy, done, hi, lo);
        end
        @(negedge clk); reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        n_checks++; if (done_seen != 0) begin
            n_fail++; $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", done_seen);
        end
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5);
        n_checks++; if (obs_hi !== 32'hFFFF_FFFF || obs_lo !== 32'hFFFF_FFF1 || obs_lat != exp_lat(2'b00, 32'd5)) begin
            n_fail++; $display("[TB] FAIL abort_restart: got %h/%h lat=%0d expected ffffffff/fffffff1 lat=%0d",
                               obs_hi, obs_lo, obs_lat, exp_lat(2'b00, 32'd5));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignored_inputs();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
